// File: rtl/merge_vga_reader.sv
// Read side of the merge double buffer: streams one 16-pixel R/G/B bank to the
// VGA output, one pixel per pixel_en, while merge fills the other bank.
// Bank swaps happen only at bank boundaries or when leaving IDLE/UNDERRUN.
//
// Handshake: there is no backpressure. pixel_en is a one-cycle request for the
// next pixel. The answer appears one clock later with pixel_valid=1. wrDone is
// a one-cycle pulse meaning "the bank being written is full". It is remembered
// in pending until the current bank has been fully read.
module merge_vga_reader #(
  parameter int PIXELS  = 16,
  parameter int COLOR_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_en,
  input  logic                        wrDone,
  input  logic [PIXELS*COLOR_W-1:0]   R_inRegA,
  input  logic [PIXELS*COLOR_W-1:0]   G_inRegA,
  input  logic [PIXELS*COLOR_W-1:0]   B_inRegA,
  input  logic [PIXELS*COLOR_W-1:0]   R_inRegB,
  input  logic [PIXELS*COLOR_W-1:0]   G_inRegB,
  input  logic [PIXELS*COLOR_W-1:0]   B_inRegB,
  output logic                        readVgaSelector,
  output logic [COLOR_W-1:0]          R_out,
  output logic [COLOR_W-1:0]          G_out,
  output logic [COLOR_W-1:0]          B_out,
  output logic                        pixel_valid,
  output logic                        line_done,
  output logic                        underrun,
  output logic                        overrun
);

  localparam int IDX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_UNDERRUN = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 sel_q, pending_q;
  logic                 valid_q, line_done_q, underrun_q, overrun_q;
  logic [COLOR_W-1:0]   r_q, g_q, b_q;
  logic [COLOR_W-1:0]   pix_r_d, pix_g_d, pix_b_d;
  logic                 last_px;

  // Select pixel idx of the bank currently being read (the selector value
  // before any toggle in this cycle).
  always_comb begin
    pix_r_d = sel_q ? R_inRegB[idx_q*COLOR_W +: COLOR_W] : R_inRegA[idx_q*COLOR_W +: COLOR_W];
    pix_g_d = sel_q ? G_inRegB[idx_q*COLOR_W +: COLOR_W] : G_inRegA[idx_q*COLOR_W +: COLOR_W];
    pix_b_d = sel_q ? B_inRegB[idx_q*COLOR_W +: COLOR_W] : B_inRegA[idx_q*COLOR_W +: COLOR_W];
    idx_d   = idx_q + 1'b1;
    last_px = pixel_en && (idx_q == LAST_IDX);
  end

  // Main FSM: bank selection, pixel index, swap bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sel_q       <= 1'b1;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      valid_q     <= 1'b0;
      line_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wrDone) begin
            sel_q   <= ~sel_q;
            idx_q   <= '0;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (pixel_en) begin
            valid_q     <= 1'b1;
            r_q         <= pix_r_d;
            g_q         <= pix_g_d;
            b_q         <= pix_b_d;
            line_done_q <= (idx_q == LAST_IDX);
          end
          if (last_px) begin
            idx_q <= '0;
            if (pending_q || wrDone) begin
              // A second full bank arriving on the boundary still counts as lost.
              if (pending_q && wrDone) overrun_q <= 1'b1;
              sel_q     <= ~sel_q;
              pending_q <= 1'b0;
            end else begin
              state_q    <= S_UNDERRUN;
              underrun_q <= 1'b1;
            end
          end else begin
            if (pixel_en) idx_q <= idx_d;
            if (wrDone) begin
              if (pending_q) overrun_q <= 1'b1;
              pending_q <= 1'b1;
            end
          end
        end
        S_UNDERRUN: begin
          if (pixel_en) begin
            valid_q <= 1'b1;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
          end
          if (wrDone) begin
            sel_q      <= ~sel_q;
            idx_q      <= '0;
            underrun_q <= 1'b0;
            state_q    <= S_STREAM;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign readVgaSelector = sel_q;
  assign R_out           = r_q;
  assign G_out           = g_q;
  assign B_out           = b_q;
  assign pixel_valid     = valid_q;
  assign line_done       = line_done_q;
  assign underrun        = underrun_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_merge_vga_reader.sv
// Bench for merge_vga_reader: fixed vector table, directed corner sequences,
// and random traffic checked against a behavioural model.
module tb_merge_vga_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, pixel_en, wrDone;
  logic [127:0] R_inRegA, G_inRegA, B_inRegA, R_inRegB, G_inRegB, B_inRegB;
  logic         readVgaSelector, pixel_valid, line_done, underrun, overrun;
  logic [7:0]   R_out, G_out, B_out;

  merge_vga_reader #(.PIXELS(16), .COLOR_W(8)) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .wrDone(wrDone),
    .R_inRegA(R_inRegA), .G_inRegA(G_inRegA), .B_inRegA(B_inRegA),
    .R_inRegB(R_inRegB), .G_inRegB(G_inRegB), .B_inRegB(B_inRegB),
    .readVgaSelector(readVgaSelector), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .pixel_valid(pixel_valid), .line_done(line_done), .underrun(underrun), .overrun(overrun)
  );

  // ---------------- bank contents ----------------
  logic [7:0] bank_r[2][16];
  logic [7:0] bank_g[2][16];
  logic [7:0] bank_b[2][16];

  task automatic pack_banks();
    for (int i = 0; i < 16; i++) begin
      R_inRegA[i*8 +: 8] = bank_r[0][i];
      G_inRegA[i*8 +: 8] = bank_g[0][i];
      B_inRegA[i*8 +: 8] = bank_b[0][i];
      R_inRegB[i*8 +: 8] = bank_r[1][i];
      G_inRegB[i*8 +: 8] = bank_g[1][i];
      B_inRegB[i*8 +: 8] = bank_b[1][i];
    end
  endtask

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit pe, input bit wd);
    reset    = r;
    pixel_en = pe;
    wrDone   = wd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Behaviour described as "which bank is shown, how far into it, how many
  // full banks are waiting"; expected outputs follow from those quantities.
  int         m_mode;      // 0 = waiting for first bank, 1 = showing a bank, 2 = starved
  int         m_pos;       // pixels of the current bank already shown
  int         m_waiting;   // full banks announced but not yet shown (0 or 1)
  bit         m_bank;      // bank being shown
  bit         m_lost;      // a full bank was ever announced while one was waiting
  bit         e_valid, e_ld;
  logic [7:0] e_r, e_g, e_b;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_waiting = 0; m_bank = 1'b1; m_lost = 1'b0;
    e_valid = 1'b0; e_ld = 1'b0; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
  endtask

  task automatic model_step(input bit r, input bit pe, input bit wd);
    bit finished;
    if (!r) begin
      model_reset();
      return;
    end
    e_valid = 1'b0;
    e_ld    = 1'b0;
    if (m_mode == 0) begin
      if (wd) begin m_bank = !m_bank; m_pos = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      finished = 1'b0;
      if (pe) begin
        e_valid = 1'b1;
        e_r = bank_r[m_bank][m_pos];
        e_g = bank_g[m_bank][m_pos];
        e_b = bank_b[m_bank][m_pos];
        m_pos = m_pos + 1;
        if (m_pos == 16) begin e_ld = 1'b1; finished = 1'b1; m_pos = 0; end
      end
      if (wd) begin
        if (m_waiting == 1) m_lost = 1'b1;
        m_waiting = 1;
      end
      if (finished) begin
        if (m_waiting == 1) begin m_bank = !m_bank; m_waiting = 0; end
        else m_mode = 2;
      end
    end else begin
      if (pe) begin e_valid = 1'b1; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00; end
      if (wd) begin m_bank = !m_bank; m_pos = 0; m_mode = 1; end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sel"},   readVgaSelector, m_bank);
    check({tag, ".valid"}, pixel_valid, e_valid);
    check({tag, ".ld"},    line_done, e_ld);
    check({tag, ".ur"},    underrun, (m_mode == 2));
    check({tag, ".ov"},    overrun, m_lost);
    check({tag, ".r"},     R_out, e_r);
    check({tag, ".g"},     G_out, e_g);
    check({tag, ".b"},     B_out, e_b);
  endtask

  task automatic step(input bit r, input bit pe, input bit wd, input string tag);
    drive(r, pe, wd);
    model_step(r, pe, wd);
    compare_all(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       rst, pe, wd;
    bit       e_sel, e_valid, e_ld, e_ur, e_ov;
    bit [7:0] e_r;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(bit rst, bit pe, bit wd, bit s, bit v, bit [7:0] rr,
                              bit ld, bit ur, bit ov);
    vec_t t;
    t.rst = rst; t.pe = pe; t.wd = wd; t.e_sel = s; t.e_valid = v;
    t.e_r = rr; t.e_ld = ld; t.e_ur = ur; t.e_ov = ov;
    return t;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] pat_r[4];
    pat_r[0] = 8'h17; pat_r[1] = 8'h30; pat_r[2] = 8'h87; pat_r[3] = 8'h30;
    for (int i = 0; i < 16; i++) begin
      bank_r[0][i] = pat_r[i % 4];   bank_r[1][i] = 8'h20 + 8'(i);
      bank_g[0][i] = 8'(i);          bank_g[1][i] = 8'h40 + 8'(i);
      bank_b[0][i] = 8'h80 + 8'(i);  bank_b[1][i] = 8'hC0 + 8'(i);
    end
    pack_banks();
    reset = 1'b0; pixel_en = 1'b0; wrDone = 1'b0;

    // Reset, pixel_en ignored in IDLE, wrDone at cycle 3, bank A streamed,
    // underrun blacks, recovery into bank B with a coincident black pixel.
    tbl[0] = mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[2] = mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[3] = mk(1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 16; k++)
      tbl[4+k] = mk(1, 1, 0, 0, 1, pat_r[k % 4], (k == 15), (k == 15), 0);
    tbl[20] = mk(1, 1, 0, 0, 1, 8'h00, 0, 1, 0);
    tbl[21] = mk(1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[22] = mk(1, 1, 1, 1, 1, 8'h00, 0, 0, 0);
    tbl[23] = mk(1, 1, 0, 1, 1, 8'h20, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      drive(tbl[i].rst, tbl[i].pe, tbl[i].wd);
      check({tag, ".sel"},   readVgaSelector, tbl[i].e_sel);
      check({tag, ".valid"}, pixel_valid, tbl[i].e_valid);
      check({tag, ".r"},     R_out, tbl[i].e_r);
      check({tag, ".ld"},    line_done, tbl[i].e_ld);
      check({tag, ".ur"},    underrun, tbl[i].e_ur);
      check({tag, ".ov"},    overrun, tbl[i].e_ov);
    end

    // wrDone during pixel 5: gapless swap to bank B after pixel 15.
    step(0, 0, 0, "gap.rst");
    step(1, 0, 1, "gap.start");
    for (int k = 0; k < 16; k++) step(1, 1, (k == 5), "gap.a");
    step(1, 1, 0, "gap.b0");
    check("gap.b0_r", R_out, 8'h20);
    check("gap.b0_ur", underrun, 1'b0);
    check("gap.b0_sel", readVgaSelector, 1'b1);
    for (int k = 0; k < 3; k++) step(1, 1, 0, "gap.b");

    // wrDone coincident with the last pixel: swap without underrun.
    step(0, 0, 0, "coin.rst");
    step(1, 0, 1, "coin.start");
    for (int k = 0; k < 15; k++) step(1, 1, 0, "coin.a");
    step(1, 1, 1, "coin.last");
    check("coin.ur", underrun, 1'b0);
    check("coin.ld", line_done, 1'b1);
    step(1, 1, 0, "coin.b0");
    check("coin.b0_r", R_out, 8'h20);

    // Two wrDone within one bank: overrun sticks, only one swap.
    step(0, 0, 0, "ov.rst");
    step(1, 0, 1, "ov.start");
    for (int k = 0; k < 16; k++) step(1, 1, (k == 2 || k == 6), "ov.a");
    check("ov.flag", overrun, 1'b1);
    for (int k = 0; k < 16; k++) step(1, (k % 3 != 1), 0, "ov.b");
    for (int k = 0; k < 6; k++) step(1, 1, 0, "ov.tail");
    check("ov.single_swap_ur", underrun, 1'b1);
    check("ov.still", overrun, 1'b1);
    step(0, 0, 0, "ov.clr");
    check("ov.cleared", overrun, 1'b0);

    // Underrun blacks, restart into new bank, reset at pixel 8.
    step(1, 0, 1, "ur.start");
    for (int k = 0; k < 16; k++) step(1, 1, 0, "ur.a");
    for (int k = 0; k < 3; k++) step(1, 1, 0, "ur.black");
    check("ur.black_valid", pixel_valid, 1'b1);
    step(1, 0, 1, "ur.restart");
    for (int k = 0; k < 8; k++) step(1, 1, 0, "ur.b");
    check("ur.b7_r", R_out, 8'h27);
    step(0, 1, 0, "ur.midrst");
    check("ur.midrst_sel", readVgaSelector, 1'b1);
    check("ur.midrst_valid", pixel_valid, 1'b0);
    check("ur.midrst_r", R_out, 8'h00);

    // Random traffic with random bank contents.
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 2; b++) begin
        bank_r[b][i] = 8'($urandom); bank_g[b][i] = 8'($urandom); bank_b[b][i] = 8'($urandom);
      end
    pack_banks();
    step(0, 0, 0, "rnd.rst");
    for (int c = 0; c < 3000; c++) begin
      bit r, pe, wd;
      r  = ($urandom_range(0, 199) != 0);
      pe = ($urandom_range(0, 3) != 0);
      wd = ($urandom_range(0, 13) == 0);
      step(r, pe, wd, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
